// File: rtl/pmem_wb_pkg.sv
// Shared types for the pmem write buffer: line data, FIFO entry, FSM states.
// Tags hold the full line-aligned address (offset bits forced to zero) so the
// struct stays fixed-width while LINE_OFFSET remains a module parameter.
package pmem_wb_pkg;

  localparam int LINE_BYTES = 32;

  typedef logic [255:0] line_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    line_t       data;
  } wb_entry_t;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} wb_state_e;

  // Clear the byte-offset bits so addresses compare per line.
  function automatic logic [31:0] line_align(input logic [31:0] addr, input int unsigned off);
    return addr & ~((32'd1 << off) - 32'd1);
  endfunction

endpackage

// File: rtl/pmem_write_buffer_wb_fifo.sv
// Circular store of buffered dirty lines with enqueue/pop/overwrite ports and a
// combinational youngest-match lookup. Enqueue and pop never coincide (the
// owning FSM issues them from different states), so count moves by one at most.
module wb_fifo
  import pmem_wb_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int LINE_OFFSET = 5,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enq,
  input  logic [31:0]      i_enq_addr,
  input  line_t            i_enq_data,
  input  logic             i_pop,
  input  logic             i_ovw,
  input  logic [PTR_W-1:0] i_ovw_idx,
  input  line_t            i_ovw_data,
  input  logic [31:0]      i_lk_addr,
  output logic             o_hit,
  output line_t            o_hit_data,
  output logic [PTR_W-1:0] o_hit_idx,
  output logic [31:0]      o_head_addr,
  output line_t            o_head_data,
  output logic             o_full,
  output logic             o_empty
);

  wb_entry_t        r_ent [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_idx;
  logic [31:0]      w_lk_line;

  assign w_lk_line   = line_align(i_lk_addr, LINE_OFFSET);
  assign o_head_addr = r_ent[r_head].tag;
  assign o_head_data = r_ent[r_head].data;
  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_empty     = (r_count == '0);

  // Entry array and pointer/count state; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_enq) begin
        r_ent[r_tail].valid <= 1'b1;
        r_ent[r_tail].tag   <= line_align(i_enq_addr, LINE_OFFSET);
        r_ent[r_tail].data  <= i_enq_data;
        r_tail              <= r_tail + 1'b1;
        r_count             <= r_count + 1'b1;
      end
      if (i_ovw) begin
        r_ent[i_ovw_idx].data <= i_ovw_data;
      end
      if (i_pop) begin
        r_ent[r_head].valid <= 1'b0;
        r_head              <= r_head + 1'b1;
        r_count             <= r_count - 1'b1;
      end
    end
  end

  // Walk from oldest (head) to youngest; a later match overrides, so the
  // entry closest to the tail wins.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_idx  = '0;
    o_hit_data = '0;
    w_idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + k[PTR_W-1:0];
      if (r_ent[w_idx].valid && (r_ent[w_idx].tag == w_lk_line)) begin
        o_hit      = 1'b1;
        o_hit_idx  = w_idx;
        o_hit_data = r_ent[w_idx].data;
      end
    end
  end

endmodule

// File: rtl/pmem_write_buffer.sv
// Write buffer between cache_group's pmem port and physical memory: absorbs
// line writebacks, forwards buffered lines to reads, drains when idle.
// Optional build macro PMEM_WB_COALESCE_EN: writes hitting a buffered line
// overwrite it in place instead of allocating a new entry.
module pmem_write_buffer
  import pmem_wb_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int LINE_OFFSET = 5,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        up_read,
  input  logic        up_write,
  input  logic [31:0] up_address,
  input  line_t       up_wdata,
  output line_t       up_rdata,
  output logic        up_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output line_t       pmem_wdata,
  input  line_t       pmem_rdata,
  input  logic        pmem_resp
);

  wb_state_e        r_state;
  line_t            r_up_rdata;
  logic             r_up_resp;
  logic             r_pmem_read;
  logic             r_pmem_write;
  logic [31:0]      r_pmem_address;
  line_t            r_pmem_wdata;

  logic             w_hit;
  line_t            w_hit_data;
  logic [PTR_W-1:0] w_hit_idx;
  logic [31:0]      w_head_addr;
  line_t            w_head_data;
  logic             w_full;
  logic             w_empty;
  logic             w_idle_wr;
  logic             w_coal;
  logic             w_enq;
  logic             w_pop;

  // A write is only acted on in IDLE and only when no read is competing.
  assign w_idle_wr = (r_state == IDLE) && !up_read && up_write;
`ifdef PMEM_WB_COALESCE_EN
  // In IDLE nothing is being drained, so any matching entry may be rewritten.
  assign w_coal = w_idle_wr && w_hit;
`else
  assign w_coal = 1'b0;
`endif
  assign w_enq = w_idle_wr && !w_full && !w_coal;
  assign w_pop = (r_state == WR) && pmem_resp;

  wb_fifo #(.DEPTH(DEPTH), .LINE_OFFSET(LINE_OFFSET)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_enq      (w_enq),
    .i_enq_addr (up_address),
    .i_enq_data (up_wdata),
    .i_pop      (w_pop),
    .i_ovw      (w_coal),
    .i_ovw_idx  (w_hit_idx),
    .i_ovw_data (up_wdata),
    .i_lk_addr  (up_address),
    .o_hit      (w_hit),
    .o_hit_data (w_hit_data),
    .o_hit_idx  (w_hit_idx),
    .o_head_addr(w_head_addr),
    .o_head_data(w_head_data),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Control FSM; every upstream and pmem output is a register set on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_up_rdata     <= '0;
      r_up_resp      <= 1'b0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (up_read && w_hit) begin
            r_up_rdata <= w_hit_data;
            r_up_resp  <= 1'b1;
            r_state    <= RESP;
          end else if (up_read) begin
            r_pmem_read    <= 1'b1;
            r_pmem_address <= line_align(up_address, LINE_OFFSET);
            r_state        <= RD;
          end else if (w_coal || w_enq) begin
            r_up_resp <= 1'b1;
            r_state   <= RESP;
          end else if (!w_empty) begin
            // Covers both idle drain and a write stalled on a full buffer;
            // head snapshot is taken here and held for the whole drain.
            r_pmem_write   <= 1'b1;
            r_pmem_address <= w_head_addr;
            r_pmem_wdata   <= w_head_data;
            r_state        <= WR;
          end
        end
        RD: begin
          if (pmem_resp) begin
            r_pmem_read <= 1'b0;
            r_up_rdata  <= pmem_rdata;
            r_up_resp   <= 1'b1;
            r_state     <= RESP;
          end
        end
        WR: begin
          if (pmem_resp) begin
            r_pmem_write <= 1'b0;
            r_state      <= IDLE;
          end
        end
        RESP: begin
          r_up_resp <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign up_rdata     = r_up_rdata;
  assign up_resp      = r_up_resp;
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;

endmodule

// File: tb/tb_pmem_write_buffer.sv
// Directed bench for pmem_write_buffer with a behavioural pmem model and
// scoreboard queues for expected pmem writes and upstream read data.
`timescale 1ns/1ps
module tb_pmem_write_buffer;
  import pmem_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        up_read, up_write;
  logic [31:0] up_address;
  line_t       up_wdata, up_rdata;
  logic        up_resp;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address;
  line_t       pmem_wdata, pmem_rdata;
  logic        pmem_resp;

  always #5 clk = ~clk;

  pmem_write_buffer #(.DEPTH(4), .LINE_OFFSET(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_read(up_read), .up_write(up_write), .up_address(up_address),
    .up_wdata(up_wdata), .up_rdata(up_rdata), .up_resp(up_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct packed { logic [31:0] addr; line_t data; } wr_t;

  wr_t   exp_wr[$];
  line_t exp_rd[$];
  line_t mem [logic [31:0]];

  int n_asrt = 0, n_fail = 0;
  int pm_lat = 3, pm_cnt = 0;
  int ev = 0, last_wr_ev = 0, last_rd_ev = 0;
  int n_pm_rd = 0, n_pm_wr = 0, max_cnt = 0;
  bit rd_seen = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic wr_t mk(input logic [31:0] a, input line_t d);
    wr_t w;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  // Physical memory model: answers after pm_lat cycles, checks drained writes
  // against the expected-write queue in arrival order.
  initial begin
    wr_t e;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (int'(dut.u_fifo.r_count) > max_cnt) max_cnt = int'(dut.u_fifo.r_count);
      if (pmem_read) rd_seen = 1'b1;
      if (!rst_n || !(pmem_read || pmem_write)) begin
        pm_cnt = 0;
      end else if (pm_cnt < pm_lat) begin
        pm_cnt++;
      end else begin
        pm_cnt    = 0;
        pmem_resp = 1'b1;
        ev++;
        chk("pm_addr_aligned", pmem_address[4:0], 5'd0);
        if (pmem_write) begin
          n_pm_wr++;
          last_wr_ev = ev;
          mem[pmem_address] = pmem_wdata;
          chk("pm_wr_expected", exp_wr.size() != 0, 1'b1);
          if (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            chk("pm_wr_addr", pmem_address, e.addr);
            chk("pm_wr_data", pmem_wdata, e.data);
          end
        end else begin
          n_pm_rd++;
          last_rd_ev = ev;
          pmem_rdata = mem.exists(pmem_address) ? mem[pmem_address] : {8{pmem_address}};
        end
      end
    end
  end

  task automatic up_wr(input logic [31:0] a, input line_t d, output int lat);
    @(negedge clk);
    up_address = a;
    up_wdata   = d;
    up_write   = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!up_resp && lat < 400);
    up_write = 1'b0;
    chk("wr_resp", up_resp, 1'b1);
    @(posedge clk); #1;
    chk("wr_resp_pulse", up_resp, 1'b0);
  endtask

  task automatic up_rd(input logic [31:0] a, input line_t e, output int lat);
    line_t x;
    exp_rd.push_back(e);
    @(negedge clk);
    up_address = a;
    up_read    = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!up_resp && lat < 400);
    up_read = 1'b0;
    chk("rd_resp", up_resp, 1'b1);
    x = exp_rd.pop_front();
    if (up_resp) chk("rd_data", up_rdata, x);
    @(posedge clk); #1;
    chk("rd_resp_pulse", up_resp, 1'b0);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 2000 && (exp_wr.size() != 0 || pmem_write); i++) begin
      @(posedge clk); #1;
    end
    chk(tag, exp_wr.size(), 0);
  endtask

  task automatic wait_pmem_write();
    for (int i = 0; i < 50 && !pmem_write; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int    lat, n0, r0;
    line_t d1, d2;

    rst_n = 1'b0; up_read = 1'b0; up_write = 1'b0; up_address = '0; up_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_up_resp", up_resp, 1'b0);
    chk("rst_up_rdata", up_rdata, '0);
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_pmem_address", pmem_address, 32'h0);
    chk("rst_pmem_wdata", pmem_wdata, '0);
    chk("rst_count", dut.u_fifo.r_count, 0);
    rst_n = 1'b1;

    // Miss read goes to pmem and returns its data.
    mem[32'h1000] = {32{8'hA5}};
    rd_seen = 0; n0 = n_pm_wr; r0 = n_pm_rd;
    up_rd(32'h0000_1000, {32{8'hA5}}, lat);
    chk("t1_pmem_read_seen", rd_seen, 1'b1);
    chk("t1_one_pmem_read", n_pm_rd - r0, 1);
    chk("t1_no_pmem_write", n_pm_wr - n0, 0);
    chk("t1_miss_latency_gt_pmem", lat >= 4, 1'b1);

    // Buffered write then forwarded read to the same line, then idle drain.
    d1 = {8{32'hD1D1_0001}};
    exp_wr.push_back(mk(32'h2000, d1));
    n0 = n_pm_wr;
    up_wr(32'h2000, d1, lat);
    chk("t2_wr_latency", lat <= 2, 1'b1);
    rd_seen = 0;
    up_rd(32'h2004, d1, lat);
    chk("t2_fwd_latency", lat <= 2, 1'b1);
    chk("t2_fwd_no_pmem_read", rd_seen, 1'b0);
    wait_drain("t2_drained");
    chk("t2_one_drain", n_pm_wr - n0, 1);

    // DEPTH+1 writes: the last one forces exactly one drain before its response.
    pm_lat = 2; max_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      d1 = {8{32'h3000_0000 + i}};
      exp_wr.push_back(mk(32'h3000 + i * 32'h20, d1));
      n0 = n_pm_wr;
      up_wr(32'h3000 + i * 32'h20, d1, lat);
      chk($sformatf("t3_fast_wr%0d", i), lat <= 2, i < 4);
      chk($sformatf("t3_drains_before_resp%0d", i), n_pm_wr - n0, (i == 4) ? 1 : 0);
    end
    wait_drain("t3_drained");
    chk("t3_max_count", max_cnt, 4);

    // Two writes to one line: read sees the younger data.
    d1 = {8{32'h4444_0001}};
    d2 = {8{32'h4444_0002}};
`ifdef PMEM_WB_COALESCE_EN
    exp_wr.push_back(mk(32'h4000, d2));
`else
    exp_wr.push_back(mk(32'h4000, d1));
    exp_wr.push_back(mk(32'h4000, d2));
`endif
    n0 = n_pm_wr;
    up_wr(32'h4000, d1, lat);
    up_wr(32'h4000, d2, lat);
    up_rd(32'h4000, d2, lat);
    wait_drain("t4_drained");
`ifdef PMEM_WB_COALESCE_EN
    chk("t4_drain_count", n_pm_wr - n0, 1);
`else
    chk("t4_drain_count", n_pm_wr - n0, 2);
`endif

    // Reset in the middle of a drain with two entries buffered.
    pm_lat = 30;
    exp_wr.push_back(mk(32'h5000, {8{32'h5555_0001}}));
    exp_wr.push_back(mk(32'h5020, {8{32'h5555_0002}}));
    up_wr(32'h5000, {8{32'h5555_0001}}, lat);
    up_wr(32'h5020, {8{32'h5555_0002}}, lat);
    wait_pmem_write();
    chk("t5_drain_active", pmem_write, 1'b1);
    chk("t5_count_before", dut.u_fifo.r_count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_pmem_write", pmem_write, 1'b0);
    chk("t5_rst_up_resp", up_resp, 1'b0);
    chk("t5_rst_count", dut.u_fifo.r_count, 0);
    exp_wr.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    pm_lat = 3; rd_seen = 0;
    up_rd(32'h5000, {8{32'h0000_5000}}, lat);
    chk("t5_read_goes_to_pmem", rd_seen, 1'b1);

    // Read miss arriving mid-drain waits for the drain, then reads pmem.
    pm_lat = 6;
    exp_wr.push_back(mk(32'h6000, {8{32'h6666_0001}}));
    up_wr(32'h6000, {8{32'h6666_0001}}, lat);
    wait_pmem_write();
    chk("t6_drain_active", pmem_write, 1'b1);
    r0 = n_pm_rd;
    up_rd(32'h7000, {8{32'h0000_7000}}, lat);
    chk("t6_drain_done_first", exp_wr.size(), 0);
    chk("t6_write_before_read", last_wr_ev < last_rd_ev, 1'b1);
    chk("t6_read_reached_pmem", n_pm_rd - r0, 1);
    wait_drain("t6_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
